// File: rtl/calc_sequencer.sv
// -----------------------------------------------------------------------------
// calc_sequencer
//
// Control FSM for the four-digit calculator. The user steps operand A, the
// operator and operand B with the slowdown tick, and advances with the
// debounced button. The result is then computed: +, -, x take one cycle.
// Division uses an iterative subtract loop, one subtraction per cycle. The
// block also drives the four character_rom addresses for the scan unit.
//
// Ports
//   clk        : system clock, all state changes on the rising edge
//   rst        : synchronous reset, active low (0 = reset)
//   tick       : one-cycle slowdown pulse, increments the field being edited
//   btn_pulse  : one-cycle debounced button pulse, advances the sequence
//   addr_1..4  : ROM addresses of the four digits, addr_1 is leftmost
//   busy       : high while in COMPUTE or DIVIDE
//   state      : current FSM state, for debug
// -----------------------------------------------------------------------------
module calc_sequencer #(
    parameter logic [4:0] CH_BLANK = 5'd31,
    parameter logic [4:0] CH_PLUS  = 5'd24,
    parameter logic [4:0] CH_MINUS = 5'd25,
    parameter logic [4:0] CH_MUL   = 5'd26,
    parameter logic [4:0] CH_DIV   = 5'd27,
    parameter logic [4:0] CH_EQ    = 5'd28,
    parameter logic [4:0] CH_NEG   = 5'd25,
    parameter logic [4:0] CH_ERR   = 5'd14
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_pulse,
    output logic [4:0] addr_1,
    output logic [4:0] addr_2,
    output logic [4:0] addr_3,
    output logic [4:0] addr_4,
    output logic       busy,
    output logic [2:0] state
);

    localparam logic [2:0] ST_ENTER_A  = 3'd0;
    localparam logic [2:0] ST_ENTER_OP = 3'd1;
    localparam logic [2:0] ST_ENTER_B  = 3'd2;
    localparam logic [2:0] ST_COMPUTE  = 3'd3;
    localparam logic [2:0] ST_DIVIDE   = 3'd4;
    localparam logic [2:0] ST_SHOW     = 3'd5;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    logic [2:0] state_r;
    logic [2:0] state_next_s;
    logic [3:0] a_r;
    logic [3:0] b_r;
    logic [1:0] op_r;
    logic [6:0] res_mag_r;
    logic       res_neg_r;
    logic       err_r;
    logic [3:0] rem_r;
    logic [3:0] quo_r;

    // Decimal digit increment with wrap from 9 back to 0.
    function automatic logic [3:0] inc_digit(input logic [3:0] d);
        logic [3:0] r;
        if (d >= 4'd9) begin
            r = 4'd0;
        end else begin
            r = d + 4'd1;
        end
        return r;
    endfunction

    // ROM address of the glyph for an operator code.
    function automatic logic [4:0] op_glyph(input logic [1:0] op);
        logic [4:0] g;
        case (op)
            OP_ADD:  g = CH_PLUS;
            OP_SUB:  g = CH_MINUS;
            OP_MUL:  g = CH_MUL;
            OP_DIV:  g = CH_DIV;
            default: g = CH_BLANK;
        endcase
        return g;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_ENTER_A;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic. The button alone moves the sequence on; tick never does.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_ENTER_A: begin
                if (btn_pulse) state_next_s = ST_ENTER_OP;
                else           state_next_s = ST_ENTER_A;
            end
            ST_ENTER_OP: begin
                if (btn_pulse) state_next_s = ST_ENTER_B;
                else           state_next_s = ST_ENTER_OP;
            end
            ST_ENTER_B: begin
                if (btn_pulse) state_next_s = ST_COMPUTE;
                else           state_next_s = ST_ENTER_B;
            end
            ST_COMPUTE: begin
                if ((op_r == OP_DIV) && (b_r != 4'd0)) state_next_s = ST_DIVIDE;
                else                                   state_next_s = ST_SHOW;
            end
            ST_DIVIDE: begin
                if (rem_r >= b_r) state_next_s = ST_DIVIDE;
                else              state_next_s = ST_SHOW;
            end
            ST_SHOW: begin
                if (btn_pulse) state_next_s = ST_ENTER_A;
                else           state_next_s = ST_SHOW;
            end
            default: state_next_s = ST_ENTER_A;
        endcase
    end

    // Operand, operator, result and divider registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_r       <= 4'd0;
            b_r       <= 4'd0;
            op_r      <= 2'd0;
            res_mag_r <= 7'd0;
            res_neg_r <= 1'b0;
            err_r     <= 1'b0;
            rem_r     <= 4'd0;
            quo_r     <= 4'd0;
        end else begin
            case (state_r)
                // A tick together with the button is dropped: only the transition happens.
                ST_ENTER_A: begin
                    if (tick && !btn_pulse) a_r <= inc_digit(a_r);
                end
                ST_ENTER_OP: begin
                    if (tick && !btn_pulse) op_r <= op_r + 2'd1;
                end
                ST_ENTER_B: begin
                    if (tick && !btn_pulse) b_r <= inc_digit(b_r);
                end
                ST_COMPUTE: begin
                    case (op_r)
                        OP_ADD: begin
                            res_mag_r <= {3'b000, a_r} + {3'b000, b_r};
                            res_neg_r <= 1'b0;
                        end
                        OP_SUB: begin
                            if (a_r < b_r) begin
                                res_mag_r <= {3'b000, b_r - a_r};
                                res_neg_r <= 1'b1;
                            end else begin
                                res_mag_r <= {3'b000, a_r - b_r};
                                res_neg_r <= 1'b0;
                            end
                        end
                        OP_MUL: begin
                            res_mag_r <= {3'b000, a_r} * {3'b000, b_r};
                            res_neg_r <= 1'b0;
                        end
                        OP_DIV: begin
                            if (b_r == 4'd0) begin
                                err_r <= 1'b1;
                            end else begin
                                rem_r <= a_r;
                                quo_r <= 4'd0;
                            end
                        end
                        default: begin
                            err_r <= 1'b1;
                        end
                    endcase
                end
                // Restoring-free repeated subtraction; exits when the remainder drops below b.
                ST_DIVIDE: begin
                    if (rem_r >= b_r) begin
                        rem_r <= rem_r - b_r;
                        quo_r <= quo_r + 4'd1;
                    end else begin
                        res_mag_r <= {3'b000, quo_r};
                        res_neg_r <= 1'b0;
                    end
                end
                ST_SHOW: begin
                    if (btn_pulse) begin
                        a_r       <= 4'd0;
                        b_r       <= 4'd0;
                        op_r      <= 2'd0;
                        err_r     <= 1'b0;
                        res_mag_r <= 7'd0;
                        res_neg_r <= 1'b0;
                    end
                end
                default: begin
                    a_r <= a_r;
                end
            endcase
        end
    end

    // Display decode and status, purely from the registers.
    always_comb begin
        addr_1 = CH_BLANK;
        addr_2 = CH_BLANK;
        addr_3 = CH_BLANK;
        addr_4 = CH_BLANK;
        busy   = 1'b0;
        state  = state_r;
        case (state_r)
            ST_ENTER_A, ST_ENTER_OP, ST_ENTER_B: begin
                addr_1 = {1'b0, a_r};
                addr_2 = op_glyph(op_r);
                addr_3 = {1'b0, b_r};
                addr_4 = CH_EQ;
            end
            ST_COMPUTE, ST_DIVIDE: begin
                busy = 1'b1;
            end
            ST_SHOW: begin
                if (err_r) begin
                    addr_4 = CH_ERR;
                end else begin
                    // Result is at most 81, so both decimal digits fit in four bits.
                    addr_2 = res_neg_r ? CH_NEG : CH_BLANK;
                    addr_3 = {1'b0, 4'(res_mag_r / 7'd10)};
                    addr_4 = {1'b0, 4'(res_mag_r % 7'd10)};
                end
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_calc_sequencer.sv
module tb_calc_sequencer;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       btn_pulse;
    logic [4:0] addr_1;
    logic [4:0] addr_2;
    logic [4:0] addr_3;
    logic [4:0] addr_4;
    logic       busy;
    logic [2:0] state;

    int vectors;
    int miscompares;

    // Reference model: the calculator fields as plain integers.
    int m_a;
    int m_op;
    int m_b;
    int glyph [4];

    calc_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .btn_pulse (btn_pulse),
        .addr_1    (addr_1),
        .addr_2    (addr_2),
        .addr_3    (addr_3),
        .addr_4    (addr_4),
        .busy      (busy),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_disp(input string tag, input int e1, input int e2, input int e3, input int e4);
        check({tag, ".addr_1"}, {27'd0, addr_1}, e1);
        check({tag, ".addr_2"}, {27'd0, addr_2}, e2);
        check({tag, ".addr_3"}, {27'd0, addr_3}, e3);
        check({tag, ".addr_4"}, {27'd0, addr_4}, e4);
    endtask

    task automatic check_enter(input string tag, input int st);
        check({tag, ".state"}, {29'd0, state}, st);
        check({tag, ".busy"}, {31'd0, busy}, 0);
        check_disp(tag, m_a, glyph[m_op], m_b, 28);
    endtask

    // One clock with the given inputs, then sample 1 time unit after the edge.
    task automatic step(input logic t, input logic b);
        tick = t;
        btn_pulse = b;
        @(posedge clk);
        #1;
        tick = 1'b0;
        btn_pulse = 1'b0;
    endtask

    task automatic model_clear();
        m_a = 0;
        m_op = 0;
        m_b = 0;
    endtask

    // Edit the three fields from ENTER_A; stops in ENTER_B before the final button.
    task automatic enter_fields(input int na, input int nop, input int nb);
        for (int i = 0; i < na; i++) begin
            step(1'b1, 1'b0);
            m_a = (m_a + 1) % 10;
            check_enter("enter_a", 0);
        end
        step($urandom_range(0, 1) == 1, 1'b1);
        check_enter("to_op", 1);
        for (int i = 0; i < nop; i++) begin
            step(1'b1, 1'b0);
            m_op = (m_op + 1) % 4;
            check_enter("enter_op", 1);
        end
        step($urandom_range(0, 1) == 1, 1'b1);
        check_enter("to_b", 2);
        for (int i = 0; i < nb; i++) begin
            step(1'b1, 1'b0);
            m_b = (m_b + 1) % 10;
            check_enter("enter_b", 2);
        end
    endtask

    task automatic check_show(input string tag, input int err, input int neg, input int mag);
        check({tag, ".state"}, {29'd0, state}, 5);
        check({tag, ".busy"}, {31'd0, busy}, 0);
        if (err != 0) check_disp(tag, 31, 31, 31, 14);
        else          check_disp(tag, 31, (neg != 0) ? 25 : 31, mag / 10, mag % 10);
    endtask

    // Full calculation: enter, compute, show, clear back to ENTER_A.
    task automatic run_calc(input int na, input int nop, input int nb);
        int mag;
        int neg;
        int err;
        int nbusy;
        enter_fields(na, nop, nb);
        mag = 0;
        neg = 0;
        err = 0;
        nbusy = 1;
        case (m_op)
            0: mag = m_a + m_b;
            1: begin
                mag = (m_a >= m_b) ? m_a - m_b : m_b - m_a;
                neg = (m_a < m_b) ? 1 : 0;
            end
            2: mag = m_a * m_b;
            default: begin
                if (m_b == 0) err = 1;
                else begin
                    mag = m_a / m_b;
                    nbusy = 2 + mag;
                end
            end
        endcase
        step($urandom_range(0, 1) == 1, 1'b1);
        for (int i = 0; i < nbusy; i++) begin
            check("busy.state", {29'd0, state}, (i == 0) ? 3 : 4);
            check("busy.busy", {31'd0, busy}, 1);
            check_disp("busy", 31, 31, 31, 31);
            step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end
        check_show("show", err, neg, mag);
        step(1'b1, 1'b0);
        check_show("show_tick", err, neg, mag);
        step(1'b0, 1'b1);
        model_clear();
        check_enter("clear", 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        glyph = '{24, 25, 26, 27};
        model_clear();
        rst = 1'b0;
        tick = 1'b0;
        btn_pulse = 1'b0;

        // Reset held for two edges.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        check_enter("reset", 0);

        // Directed calculations from the test plan.
        run_calc(7, 2, 9);
        run_calc(3, 1, 8);
        run_calc(9, 3, 2);
        run_calc(5, 3, 0);

        // tick and button together in ENTER_A: transition only, a stays 4.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0);
            m_a = m_a + 1;
        end
        step(1'b1, 1'b1);
        check_enter("tick_btn_prio", 1);
        rst = 1'b0;
        step(1'b0, 1'b0);
        rst = 1'b1;
        model_clear();
        check_enter("reset_enter_op", 0);

        // Reset on the third DIVIDE cycle of 9/1 aborts with no SHOW.
        enter_fields(9, 3, 1);
        step(1'b0, 1'b1);
        check("mid_div.compute", {29'd0, state}, 3);
        repeat (3) step(1'b0, 1'b0);
        check("mid_div.divide", {29'd0, state}, 4);
        check("mid_div.busy", {31'd0, busy}, 1);
        rst = 1'b0;
        step(1'b0, 1'b0);
        rst = 1'b1;
        model_clear();
        check_enter("mid_div_reset", 0);

        // Randomized calculations, including wrap of every field.
        repeat (25) begin
            run_calc($urandom_range(0, 12), $urandom_range(0, 5), $urandom_range(0, 12));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
